// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: op/type codes, FSM state
// encoding, instruction field bit positions and the decoded-field payload.
package seq_pkg;

  localparam logic [1:0] OP_SW  = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  localparam logic [1:0] TY_MEM = 2'b00;
  localparam logic [1:0] TY_IO  = 2'b11;

  // Instruction field bit positions
  localparam int unsigned OP_MSB   = 15;
  localparam int unsigned OP_LSB   = 14;
  localparam int unsigned TY_MSB   = 13;
  localparam int unsigned TY_LSB   = 12;
  localparam int unsigned RD_MSB   = 11;
  localparam int unsigned RD_LSB   = 8;
  localparam int unsigned RS_MSB   = 7;
  localparam int unsigned RS_LSB   = 4;
  localparam int unsigned RT_MSB   = 3;
  localparam int unsigned RT_LSB   = 0;
  localparam int unsigned ADDR_MSB = 7;
  localparam int unsigned ADDR_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_BUS_WAIT,
    S_XFER
  } state_t;

  typedef struct packed {
    logic [1:0] op;
    logic [1:0] ty;
    logic [3:0] rd;
    logic [3:0] rs;
    logic [3:0] rt;
    logic [7:0] addr;
    logic       is_alu;
    logic       is_lw;
    logic       is_sw;
    logic       illegal;
  } fields_t;

endpackage

// File: rtl/seq_decode.sv
// Combinational instruction field extractor.
// Ports: instr   - raw 16-bit instruction
//        fields_c - decoded fields plus op class and illegal flag (unregistered)
module seq_decode
  import seq_pkg::*;
(
  input  logic [15:0] instr,
  output fields_t     fields_c
);

  always_comb begin
    fields_c         = '0;
    fields_c.op      = instr[OP_MSB:OP_LSB];
    fields_c.ty      = instr[TY_MSB:TY_LSB];
    fields_c.rd      = instr[RD_MSB:RD_LSB];
    fields_c.rs      = instr[RS_MSB:RS_LSB];
    fields_c.rt      = instr[RT_MSB:RT_LSB];
    fields_c.addr    = instr[ADDR_MSB:ADDR_LSB];
    fields_c.is_alu  = (fields_c.op == OP_ADD) || (fields_c.op == OP_SUB);
    fields_c.is_lw   = (fields_c.op == OP_LW);
    fields_c.is_sw   = (fields_c.op == OP_SW);
    // Memory ops only allow the memory and IO transfer types
    fields_c.illegal = !fields_c.is_alu &&
                       (fields_c.ty != TY_MEM) && (fields_c.ty != TY_IO);
  end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: accepts 16-bit instructions, drives register-file
// controls for ALU ops and arbitrates the shared data bus for lw/sw with a
// grant timeout.
// Ports: clk, rst (sync, active-high); instr_valid/instr/instr_ready handshake;
//        bus_req/bus_grant bus arbitration; op, xfer_type, Readreg1, Readreg2,
//        Writereg, fake_source, fake_destination, RegWrite, mem_addr register
//        file / memory controls; err one-cycle error pulse.
// The transfer-type output is named xfer_type because "type" is a keyword.
// Optional: SEQ_RETIRE_CNT_EN adds retired[15:0], a wrapping count of
// instructions that complete EXEC or XFER.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 15,
  parameter int unsigned INSTR_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  input  logic               bus_grant,
  output logic               bus_req,
  output logic [1:0]         op,
  output logic [1:0]         xfer_type,
  output logic [3:0]         Readreg1,
  output logic [3:0]         Readreg2,
  output logic [3:0]         Writereg,
  output logic [7:0]         fake_source,
  output logic [7:0]         fake_destination,
  output logic               RegWrite,
  output logic [7:0]         mem_addr,
`ifdef SEQ_RETIRE_CNT_EN
  output logic [15:0]        retired,
`endif
  output logic               err
);

  localparam int unsigned CNT_W = $clog2(BUS_TIMEOUT + 1);

  state_t           state;
  fields_t          dec;
  logic [1:0]       cur_op;
  logic             cur_illegal;
  logic [CNT_W-1:0] wait_cnt;

  seq_decode u_decode (
    .instr    (instr),
    .fields_c (dec)
  );

  // FSM, timeout counter and all output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      instr_ready      <= 1'b1;
      bus_req          <= 1'b0;
      op               <= OP_ADD;
      xfer_type        <= TY_MEM;
      Readreg1         <= 4'h0;
      Readreg2         <= 4'h0;
      Writereg         <= 4'h0;
      fake_source      <= 8'h00;
      fake_destination <= 8'h00;
      RegWrite         <= 1'b0;
      mem_addr         <= 8'h00;
      err              <= 1'b0;
      wait_cnt         <= '0;
      cur_op           <= OP_ADD;
      cur_illegal      <= 1'b0;
`ifdef SEQ_RETIRE_CNT_EN
      retired          <= 16'h0000;
`endif
    end else begin
      err      <= 1'b0;
      RegWrite <= 1'b0;
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            state            <= S_DECODE;
            instr_ready      <= 1'b0;
            cur_op           <= dec.op;
            cur_illegal      <= dec.illegal;
            op               <= dec.op;
            xfer_type        <= dec.ty;
            Writereg         <= dec.rd;
            Readreg1         <= dec.rs;
            Readreg2         <= dec.rt;
            fake_source      <= dec.is_sw ? {4'h0, dec.rd} : 8'h00;
            fake_destination <= dec.is_lw ? {4'h0, dec.rd} : 8'h00;
            mem_addr         <= dec.is_alu ? 8'h00 : dec.addr;
          end
        end
        S_DECODE: begin
          if (cur_op[1]) begin
            state    <= S_EXEC;
            RegWrite <= 1'b1;
          end else if (cur_illegal) begin
            state       <= S_IDLE;
            instr_ready <= 1'b1;
            err         <= 1'b1;
            op          <= OP_ADD;
          end else begin
            state    <= S_BUS_WAIT;
            bus_req  <= 1'b1;
            wait_cnt <= '0;
            op       <= OP_ADD;
          end
        end
        S_EXEC: begin
          state       <= S_IDLE;
          instr_ready <= 1'b1;
          op          <= OP_ADD;
`ifdef SEQ_RETIRE_CNT_EN
          retired     <= retired + 16'h0001;
`endif
        end
        S_BUS_WAIT: begin
          // A grant wins over a timeout expiring in the same cycle
          if (bus_grant) begin
            state    <= S_XFER;
            op       <= cur_op;
            RegWrite <= (cur_op == OP_LW);
          end else if (wait_cnt == CNT_W'(BUS_TIMEOUT - 1)) begin
            state       <= S_IDLE;
            instr_ready <= 1'b1;
            bus_req     <= 1'b0;
            err         <= 1'b1;
            wait_cnt    <= '0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_XFER: begin
          state       <= S_IDLE;
          instr_ready <= 1'b1;
          bus_req     <= 1'b0;
          op          <= OP_ADD;
`ifdef SEQ_RETIRE_CNT_EN
          retired     <= retired + 16'h0001;
`endif
        end
        default: begin
          state       <= S_IDLE;
          instr_ready <= 1'b1;
          bus_req     <= 1'b0;
          op          <= OP_ADD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed cases plus randomized
// instructions and grant delays, checked against a per-cycle timeline model.
module tb_instr_sequencer;

  localparam int T = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic        bus_grant;
  logic        bus_req;
  logic [1:0]  op;
  logic [1:0]  xfer_type;
  logic [3:0]  Readreg1;
  logic [3:0]  Readreg2;
  logic [3:0]  Writereg;
  logic [7:0]  fake_source;
  logic [7:0]  fake_destination;
  logic        RegWrite;
  logic [7:0]  mem_addr;
  logic        err;
`ifdef SEQ_RETIRE_CNT_EN
  logic [15:0] retired;
`endif

  always #5 clk = ~clk;

  instr_sequencer #(.BUS_TIMEOUT(T), .INSTR_W(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .instr_valid      (instr_valid),
    .instr            (instr),
    .instr_ready      (instr_ready),
    .bus_grant        (bus_grant),
    .bus_req          (bus_req),
    .op               (op),
    .xfer_type        (xfer_type),
    .Readreg1         (Readreg1),
    .Readreg2         (Readreg2),
    .Writereg         (Writereg),
    .fake_source      (fake_source),
    .fake_destination (fake_destination),
    .RegWrite         (RegWrite),
    .mem_addr         (mem_addr),
`ifdef SEQ_RETIRE_CNT_EN
    .retired          (retired),
`endif
    .err              (err)
  );

  int total = 0;
  int bad   = 0;
  int retired_model = 0;

  task automatic check_eq(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  typedef struct {
    bit ready;
    int op;
    bit rw;
    bit br;
    bit err;
    bit last;
  } exp_t;

  // Expected outputs k cycles after acceptance, from the instruction's
  // timeline: decode, then exec / bus wait + transfer / abort, then idle.
  function automatic exp_t model(input logic [15:0] ins, input int g, input int k);
    exp_t e;
    int opc = int'(ins[15:14]);
    int ty  = int'(ins[13:12]);
    bit alu = (opc >= 2);
    bit ill = !alu && (ty == 1 || ty == 2);
    int nw;
    e.ready = 1; e.op = 2; e.rw = 0; e.br = 0; e.err = 0; e.last = 1;
    if (k == 1) begin
      e.ready = 0; e.op = opc; e.last = 0;
    end else if (alu) begin
      if (k == 2) begin
        e.ready = 0; e.op = opc; e.rw = 1; e.last = 0;
      end
    end else if (ill) begin
      e.err = 1;
    end else begin
      nw = (g < T) ? g + 1 : T;
      if (k <= 1 + nw) begin
        e.ready = 0; e.br = 1; e.last = 0;
      end else if (g < T) begin
        if (k == 2 + nw) begin
          e.ready = 0; e.op = opc; e.rw = (opc == 1); e.br = 1; e.last = 0;
        end
      end else begin
        e.err = 1;
      end
    end
    return e;
  endfunction

  function automatic bit retires(input logic [15:0] ins, input int g);
    int opc = int'(ins[15:14]);
    int ty  = int'(ins[13:12]);
    if (opc >= 2) return 1;
    if (ty == 1 || ty == 2) return 0;
    return (g < T);
  endfunction

  task automatic check_ctl(input string tag, input exp_t e);
    check_eq({tag, ".ready"}, int'(instr_ready), int'(e.ready));
    check_eq({tag, ".op"},    int'(op),          e.op);
    check_eq({tag, ".rw"},    int'(RegWrite),    int'(e.rw));
    check_eq({tag, ".breq"},  int'(bus_req),     int'(e.br));
    check_eq({tag, ".err"},   int'(err),         int'(e.err));
  endtask

  task automatic idle_cycles(input int n);
    exp_t e;
    e.ready = 1; e.op = 2; e.rw = 0; e.br = 0; e.err = 0; e.last = 1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      instr_valid = 1'b0;
      bus_grant   = 1'($urandom);
      @(negedge clk);
      check_ctl("idle", e);
    end
  endtask

  // Offer one instruction, then follow it until it returns to idle.
  // g = number of BUS_WAIT cycles with bus_grant low before grant rises.
  task automatic run_instr(input logic [15:0] ins, input int g, input int gap);
    exp_t e;
    bit   done = 0;
    int   rd   = int'(ins[11:8]);
    int   opc  = int'(ins[15:14]);
    idle_cycles(gap);
    @(posedge clk); #1;
    instr_valid = 1'b1;
    instr       = ins;
    bus_grant   = 1'($urandom);
    @(negedge clk);
    check_eq("offer.ready", int'(instr_ready), 1);
    for (int k = 1; k < 64 && !done; k++) begin
      @(posedge clk); #1;
      instr_valid = 1'b0;
      instr       = 16'($urandom);
      bus_grant   = (k >= 2) ? (k - 2 >= g) : 1'($urandom);
      @(negedge clk);
      e = model(ins, g, k);
      check_ctl($sformatf("i%04h.k%0d", ins, k), e);
      if (k == 1) begin
        check_eq("dec.type", int'(xfer_type), int'(ins[13:12]));
        check_eq("dec.wreg", int'(Writereg),  rd);
        check_eq("dec.rr1",  int'(Readreg1),  int'(ins[7:4]));
        check_eq("dec.rr2",  int'(Readreg2),  int'(ins[3:0]));
        if (opc < 2) check_eq("dec.maddr", int'(mem_addr), int'(ins[7:0]));
        if (opc == 0) check_eq("dec.fsrc", int'(fake_source), rd);
        if (opc == 1) check_eq("dec.fdst", int'(fake_destination), rd);
      end
      if (e.rw && opc >= 2) begin
        check_eq("exec.wreg", int'(Writereg), rd);
        check_eq("exec.rr1",  int'(Readreg1), int'(ins[7:4]));
        check_eq("exec.rr2",  int'(Readreg2), int'(ins[3:0]));
      end
      if (e.br && e.op != 2) begin
        check_eq("xfer.maddr", int'(mem_addr), int'(ins[7:0]));
        if (opc == 0) check_eq("xfer.fsrc", int'(fake_source), rd);
        else          check_eq("xfer.fdst", int'(fake_destination), rd);
      end
      if (e.last) begin
        done = 1;
        if (retires(ins, g)) retired_model = (retired_model + 1) % 65536;
`ifdef SEQ_RETIRE_CNT_EN
        check_eq("retired", int'(retired), retired_model);
`endif
      end
    end
    if (!done) check_eq("op_complete", int'(done), 1);
  endtask

  initial begin
    logic [15:0] ri;
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    bus_grant   = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rst.ready", int'(instr_ready), 1);
    check_eq("rst.op",    int'(op), 2);
    check_eq("rst.type",  int'(xfer_type), 0);
    check_eq("rst.idx",   int'({Readreg1, Readreg2, Writereg}), 0);
    check_eq("rst.fake",  int'({fake_source, fake_destination}), 0);
    check_eq("rst.maddr", int'(mem_addr), 0);
    check_eq("rst.rw",    int'(RegWrite), 0);
    check_eq("rst.breq",  int'(bus_req), 0);
    check_eq("rst.err",   int'(err), 0);
`ifdef SEQ_RETIRE_CNT_EN
    check_eq("rst.retired", int'(retired), 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases
    run_instr(16'h8321, 0, 1);   // add
    run_instr(16'h4540, 0, 1);   // lw, grant immediately
    run_instr(16'h3A7F, 4, 1);   // sw to IO, grant 4 cycles late
    run_instr(16'h4540, 20, 1);  // lw timeout
    run_instr(16'h1100, 0, 1);   // illegal type
    run_instr(16'h0012, T - 1, 0); // grant on the last allowed wait cycle
    run_instr(16'hC5AB, 0, 0);   // sub

    // Reset during BUS_WAIT
    idle_cycles(1);
    @(posedge clk); #1;
    instr_valid = 1'b1;
    instr       = 16'h4540;
    bus_grant   = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      instr_valid = 1'b0;
      bus_grant   = 1'b0;
    end
    @(negedge clk);
    check_eq("mid.breq", int'(bus_req), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    retired_model = 0;
    @(negedge clk);
    check_eq("rstmid.ready", int'(instr_ready), 1);
    check_eq("rstmid.breq",  int'(bus_req), 0);
    check_eq("rstmid.op",    int'(op), 2);
    check_eq("rstmid.rw",    int'(RegWrite), 0);
`ifdef SEQ_RETIRE_CNT_EN
    check_eq("rstmid.retired", int'(retired), 0);
`endif
    idle_cycles(2);

    // Randomized instructions and grant delays
    for (int n = 0; n < 80; n++) begin
      ri = 16'($urandom);
      run_instr(ri, int'($urandom_range(0, 20)), int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
